// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: serial frame receiver (start bit, WIDTH data bits MSB-first, stop bit)
// with a holding register offered on a valid/ready handshake and sticky error flags.
// Optional even-parity stage between data and stop: define SIPO_PARITY_EN.
module sipo_frame_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             si,
    input  logic             po_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err
);
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] r_po;
    logic             r_po_valid;
    logic             r_frame_err;
    logic             r_overrun;

    logic w_stop_smp;
    logic w_good;
    logic w_ferr;
    logic w_load;
    logic w_ovr;

    assign w_stop_smp = bit_en && (r_state == S_STOP);
    assign w_ferr     = w_stop_smp && !si;

`ifdef SIPO_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;
    logic w_perr;

    // Data XOR parity bit must be zero for even parity
    assign w_perr = bit_en && (r_state == S_PARITY) && ((^r_shreg) ^ si);
    assign w_good = w_stop_smp && si && !r_par_bad;
`else
    assign w_good = w_stop_smp && si;
`endif

    // A good word is taken if the holding register is free or being drained this edge
    assign w_load = w_good && (!r_po_valid || po_ready);
    assign w_ovr  = w_good && r_po_valid && !po_ready;

    // Frame sequencer: start detect, data shifting, optional parity, stop check
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
`ifdef SIPO_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else if (bit_en) begin
            case (r_state)
                S_IDLE: begin
                    if (!si) begin
                        r_state <= S_DATA;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_DATA: begin
                    r_shreg <= {r_shreg[WIDTH-2:0], si};
                    if (r_cnt == LAST_CNT) begin
                        r_cnt <= '0;
`ifdef SIPO_PARITY_EN
                        r_state <= S_PARITY;
`else
                        r_state <= S_STOP;
`endif
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`ifdef SIPO_PARITY_EN
                S_PARITY: begin
                    r_par_bad <= w_perr;
                    r_state   <= S_STOP;
                end
`endif
                S_STOP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
`ifdef SIPO_PARITY_EN
                    r_par_bad <= 1'b0;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Holding register and valid/ready handshake, active on every edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_po       <= '0;
            r_po_valid <= 1'b0;
        end else if (w_load) begin
            r_po       <= r_shreg;
            r_po_valid <= 1'b1;
        end else if (r_po_valid && po_ready) begin
            r_po_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr || (r_frame_err && !clr_err);
            r_overrun   <= w_ovr || (r_overrun && !clr_err);
        end
    end

`ifdef SIPO_PARITY_EN
    // Sticky parity flag, raised on the parity sample
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_perr || (r_parity_err && !clr_err);
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign po        = r_po;
    assign po_valid  = r_po_valid;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl: directed frames checked against a queue-based frame model every cycle,
// plus literal expectations at key points.
module tb_sipo_frame_ctrl;
    localparam int unsigned W = 4;
`ifdef SIPO_PARITY_EN
    localparam int unsigned NP = 1;
`else
    localparam int unsigned NP = 0;
`endif

    logic         clk;
    logic         rst;
    logic         bit_en;
    logic         si;
    logic         po_ready;
    logic         clr_err;
    logic [W-1:0] po;
    logic         po_valid;
    logic         busy;
    logic         frame_err;
    logic         overrun;
    logic         parity_err;

    int n_checks = 0;
    int n_err    = 0;

    sipo_frame_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .si         (si),
        .po_ready   (po_ready),
        .clr_err    (clr_err),
        .po         (po),
        .po_valid   (po_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is the list of bit_en samples following a start sample
    bit           m_in;
    int           m_q[$];
    logic [W-1:0] m_po;
    bit           m_valid, m_ferr, m_ovr, m_perr;

    always @(posedge clk or negedge rst) begin : model
        bit           done, fev, pev, oev;
        logic [W-1:0] word;
        int           par;
        if (!rst) begin
            m_in = 0; m_q.delete(); m_po = '0;
            m_valid = 0; m_ferr = 0; m_ovr = 0; m_perr = 0;
        end else begin
            done = 0; fev = 0; pev = 0; oev = 0; word = '0; par = 0;
            if (bit_en) begin
                if (!m_in) begin
                    if (!si) begin m_in = 1; m_q.delete(); end
                end else begin
                    m_q.push_back(int'(si));
                    for (int i = 0; i < m_q.size(); i++) par ^= m_q[i];
                    if (NP == 1 && m_q.size() == W + 1) pev = (par != 0);
                    if (m_q.size() == W + NP + 1) begin
                        m_in = 0;
                        for (int i = 0; i < W; i++) word = {word[W-2:0], m_q[i][0]};
                        par = 0;
                        for (int i = 0; i < W + NP; i++) par ^= m_q[i];
                        if (!si) fev = 1;
                        else if (NP == 0 || par == 0) done = 1;
                    end
                end
            end
            if (done) begin
                if (!m_valid || po_ready) begin m_po = word; m_valid = 1; end
                else oev = 1;
            end else if (m_valid && po_ready) begin
                m_valid = 0;
            end
            m_ferr = fev || (m_ferr && !clr_err);
            m_ovr  = oev || (m_ovr && !clr_err);
            m_perr = pev || (m_perr && !clr_err);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("po", 32'(po), 32'(m_po));
            chk("po_valid", 32'(po_valid), 32'(m_valid));
            chk("busy", 32'(busy), 32'(m_in));
            chk("frame_err", 32'(frame_err), 32'(m_ferr));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("parity_err", 32'(parity_err), 32'(m_perr));
        end
    end

    task automatic cyc(input bit be, input bit s, input bit rdy, input bit clr);
        @(negedge clk);
        bit_en = be; si = s; po_ready = rdy; clr_err = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 1, 0, 0);
    endtask

    // Start bit, data MSB first, optional parity, stop; gap-1 non-strobe cycles with inverted si
    task automatic send_frame(input logic [W-1:0] d, input bit stop, input int gap,
                              input bit rdy_last, input bit clr_last, input bit pflip);
        bit b[$];
        b.push_back(1'b0);
        for (int i = W - 1; i >= 0; i--) b.push_back(d[i]);
        if (NP == 1) b.push_back((^d) ^ pflip);
        b.push_back(stop);
        for (int k = 0; k < b.size(); k++) begin
            for (int g = 1; g < gap; g++) cyc(0, !b[k], 0, 0);
            if (k == b.size() - 1) cyc(1, b[k], rdy_last, clr_last);
            else cyc(1, b[k], 0, 0);
        end
    endtask

    initial begin
        rst = 1'b1; bit_en = 0; si = 1; po_ready = 0; clr_err = 0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(1);
        chk("rst_po", 32'(po), 32'h0);
        chk("rst_valid", 32'(po_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_flags", 32'({frame_err, overrun, parity_err}), 32'h0);

        // Basic frame 1011, then consume
        send_frame(4'b1011, 1, 1, 0, 0, 0);
        idle(1);
        chk("basic_po", 32'(po), 32'hB);
        chk("basic_valid", 32'(po_valid), 32'h1);
        chk("basic_busy", 32'(busy), 32'h0);
        cyc(0, 1, 1, 0);
        idle(1);
        chk("consume_valid", 32'(po_valid), 32'h0);

        // Framing error, clear, then good frame 0110
        send_frame(4'b1010, 0, 1, 0, 0, 0);
        idle(1);
        chk("ferr_set", 32'(frame_err), 32'h1);
        chk("ferr_novalid", 32'(po_valid), 32'h0);
        cyc(0, 1, 0, 1);
        idle(1);
        chk("ferr_clr", 32'(frame_err), 32'h0);
        send_frame(4'b0110, 1, 1, 0, 0, 0);
        idle(1);
        chk("after_clr_po", 32'(po), 32'h6);
        cyc(0, 1, 1, 0);

        // Error event coincident with clear: set wins
        send_frame(4'b1100, 0, 1, 0, 1, 0);
        idle(1);
        chk("set_wins", 32'(frame_err), 32'h1);
        cyc(0, 1, 0, 1);

        // Overrun: back-to-back frames with po_ready low
        send_frame(4'b1011, 1, 1, 0, 0, 0);
        send_frame(4'b0101, 1, 1, 0, 0, 0);
        idle(1);
        chk("ovr_po", 32'(po), 32'hB);
        chk("ovr_flag", 32'(overrun), 32'h1);
        cyc(0, 1, 1, 1);
        idle(1);
        chk("ovr_clr", 32'(overrun), 32'h0);
        send_frame(4'b1011, 1, 1, 0, 0, 0);
        send_frame(4'b0101, 1, 1, 1, 0, 0);
        idle(1);
        chk("ready_po", 32'(po), 32'h5);
        chk("ready_ovr", 32'(overrun), 32'h0);
        chk("ready_valid", 32'(po_valid), 32'h1);
        cyc(0, 1, 1, 0);

        // Strobe every 3rd cycle with si toggled in between
        send_frame(4'b1011, 1, 3, 0, 0, 0);
        idle(2);
        chk("gap_po", 32'(po), 32'hB);
        chk("gap_valid", 32'(po_valid), 32'h1);

        // Mid-frame async reset with a held word and a set flag
        send_frame(4'b0000, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        chk("pre_rst_ferr", 32'(frame_err), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("async_po", 32'(po), 32'h0);
        chk("async_valid", 32'(po_valid), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_flags", 32'({frame_err, overrun, parity_err}), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        send_frame(4'b0011, 1, 1, 0, 0, 0);
        idle(1);
        chk("post_rst_po", 32'(po), 32'h3);
        chk("post_rst_flags", 32'({frame_err, overrun, parity_err}), 32'h0);
        cyc(0, 1, 1, 0);

`ifdef SIPO_PARITY_EN
        send_frame(4'b1011, 1, 1, 0, 0, 0);
        idle(1);
        chk("par_good_po", 32'(po), 32'hB);
        cyc(0, 1, 1, 0);
        send_frame(4'b1011, 1, 1, 0, 0, 1);
        idle(1);
        chk("par_bad_flag", 32'(parity_err), 32'h1);
        chk("par_bad_valid", 32'(po_valid), 32'h0);
`endif

        idle(3);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
